// File: rtl/osc_trig_capture.sv
// Multi-channel circular-buffer capture with an edge/hysteresis trigger, a programmable
// pre-trigger depth and a timeout that forces capture; the record is drained oldest-first.
module osc_trig_capture #(
  parameter int DW    = 8,
  parameter int NCH   = 2,
  parameter int DEPTH = 1024,
  parameter int TW    = 27,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] din,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [CW-1:0]     trig_ch,
  input  logic [1:0]        edge_mode,
  input  logic [DW-1:0]     level,
  input  logic [DW-1:0]     hyst,
  input  logic [AW-1:0]     hpos,
  input  logic [TW-1:0]     to,
  input  logic              rd,
  output logic [NCH*DW-1:0] dout,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              trig_flag
);

  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

  state_t state_q, state_d;

  logic [NCH*DW-1:0] mem [DEPTH];

  logic [AW-1:0] wp, rp, cnt, rd_cnt, hpos_q;
  logic [TW-1:0] to_cnt, to_q;
  logic [CW-1:0] trig_ch_q;
  logic [1:0]    edge_q;
  logic [DW-1:0] level_q, hyst_q;
  logic          arm_r, arm_f;

  logic signed [DW-1:0] trig_sample;
  logic signed [DW+1:0] s_x, lvl_x, hyst_x, lo_x, hi_x;
  logic fire_real, fire_to, pre_last, post_last, post_empty, rd_last;
  logic start_ok, wr_en, rd_en;

  always_comb begin
    trig_sample = din[DW-1:0];
    for (int k = 1; k < NCH; k++) begin
      if (trig_ch_q == CW'(k)) trig_sample = din[k*DW +: DW];
    end
  end

  // Two extra bits keep level +/- hyst exact for any level/hyst pair.
  assign s_x    = {{2{trig_sample[DW-1]}}, trig_sample};
  assign lvl_x  = {{2{level_q[DW-1]}}, level_q};
  assign hyst_x = {2'b00, hyst_q};
  assign lo_x   = lvl_x - hyst_x;
  assign hi_x   = lvl_x + hyst_x;

  assign fire_real = (edge_q[0] & arm_r & (s_x >= lvl_x)) |
                     (edge_q[1] & arm_f & (s_x <= lvl_x));
  assign fire_to   = (to_q != '0) && (to_cnt + TW'(1) == to_q);

  assign pre_last   = (cnt + AW'(1) == hpos_q);
  assign post_empty = (hpos_q == AW'(DEPTH - 1));
  assign post_last  = (cnt + AW'(1) == AW'(DEPTH - 1) - hpos_q);
  assign rd_last    = (rd_cnt == AW'(DEPTH - 1));

  assign start_ok = start && !abort && (state_q == IDLE || state_q == DONE);
  assign wr_en    = en && !abort &&
                    (state_q == PRE || state_q == WAIT || (state_q == POST && !post_empty));
  assign rd_en    = rd && !abort && !start && (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
    done    = (state_q == DONE);
    if (abort) begin
      state_d = IDLE;
    end else if (start_ok) begin
      state_d = (hpos == '0) ? WAIT : PRE;
    end else begin
      unique case (state_q)
        PRE:     if (wr_en && pre_last) state_d = WAIT;
        WAIT:    if (wr_en && (fire_real || fire_to)) state_d = POST;
        POST:    if (post_empty || (wr_en && post_last)) state_d = DONE;
        DONE:    if (rd_en && rd_last) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Counters, arming and config latches; the trigger address is folded directly into rp.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      to_cnt    <= '0;
      arm_r     <= 1'b0;
      arm_f     <= 1'b0;
      trig_flag <= 1'b0;
      rd_valid  <= 1'b0;
      hpos_q    <= '0;
      to_q      <= '0;
      trig_ch_q <= '0;
      edge_q    <= '0;
      level_q   <= '0;
      hyst_q    <= '0;
    end else begin
      rd_valid <= rd_en;
      if (start_ok) begin
        hpos_q    <= hpos;
        to_q      <= to;
        trig_ch_q <= trig_ch;
        edge_q    <= edge_mode;
        level_q   <= level;
        hyst_q    <= hyst;
        wp        <= '0;
        cnt       <= '0;
        rd_cnt    <= '0;
        to_cnt    <= '0;
        arm_r     <= 1'b0;
        arm_f     <= 1'b0;
        trig_flag <= 1'b0;
      end else begin
        if (wr_en) wp <= wp + AW'(1);
        if (wr_en && state_q == PRE) begin
          cnt <= pre_last ? '0 : cnt + AW'(1);
          if (pre_last) begin
            arm_r  <= 1'b0;
            arm_f  <= 1'b0;
            to_cnt <= '0;
          end
        end
        if (wr_en && state_q == WAIT) begin
          to_cnt <= to_cnt + TW'(1);
          if (fire_real || fire_to) begin
            trig_flag <= fire_real;
            rp        <= wp - hpos_q;
            cnt       <= '0;
            arm_r     <= 1'b0;
            arm_f     <= 1'b0;
          end else begin
            arm_r <= arm_r | (s_x < lo_x);
            arm_f <= arm_f | (s_x > hi_x);
          end
        end
        if (wr_en && state_q == POST) cnt <= cnt + AW'(1);
        if (rd_en) begin
          rp     <= rp + AW'(1);
          rd_cnt <= rd_cnt + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst)        dout <= '0;
    else if (rd_en) dout <= mem[rp];
  end

endmodule
